// File: rtl/seg7_pkg.sv
// Shared types, widths and the seven-segment lookup for the scan driver.
package seg7_pkg;

  localparam int unsigned BIN_W      = 8;
  localparam int unsigned DIG_W      = 4;
  localparam int unsigned MAX_DIGITS = 3;
  localparam int unsigned BCD_W      = DIG_W * MAX_DIGITS;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned AN_W       = 8;
  localparam int unsigned IDX_W      = 2;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
  localparam logic [AN_W-1:0]  AN_RST    = 8'hFE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  // Committed display contents: three digits, decimal flag and digit count.
  typedef struct packed {
    logic [BCD_W-1:0] digits;
    logic             dec;
    logic [IDX_W-1:0] count;
  } disp_t;

  localparam disp_t DISP_RST = '{digits: '0, dec: 1'b1, count: 2'd1};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [SEG_W-1:0] seg_lut(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd8.sv
// Serial double-dabble: converts one 8-bit binary value to 3 BCD digits, one bit per cycle.
module bin2bcd8
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_c_o
);

  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj_c;
  logic [2:0]       cnt_q, cnt_d;
  logic             run_q, run_d;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    adj_c = bcd_q;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (bcd_q[i*DIG_W +: DIG_W] >= 4'd5) begin
        adj_c[i*DIG_W +: DIG_W] = bcd_q[i*DIG_W +: DIG_W] + 4'd3;
      end
    end
  end

  // Load on start, otherwise shift one binary bit into the BCD register per cycle.
  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      sh_d  = bin_i;
      bcd_d = '0;
      cnt_d = 3'd0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj_c[BCD_W-2:0], sh_q[BIN_W-1]};
      sh_d  = {sh_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        run_d = 1'b0;
      end
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= 3'd0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // High during the cycle in which the final bit is shifted in.
  assign done_c_o = run_q && (cnt_q == 3'd7);
  assign bcd_o    = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures display bytes, converts to hex or decimal digits and scans them onto an 8-digit display.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [BIN_W-1:0] wr_data,
  input  logic             mode,
  output logic [AN_W-1:0]  an,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic             busy
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  state_e           state_q, state_d;
  logic [BIN_W-1:0] cur_data_q, cur_data_d;
  logic             cur_mode_q, cur_mode_d;
  logic             pend_vld_q, pend_vld_d;
  logic [BIN_W-1:0] pend_data_q, pend_data_d;
  logic             pend_mode_q, pend_mode_d;
  disp_t            disp_q, disp_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             busy_q, busy_d;

  logic             start_c;
  logic [BIN_W-1:0] start_bin_c;
  logic             load_c;
  logic             done_c;
  logic [BCD_W-1:0] bcd_c;
  logic             wrap_c;
  logic [DIG_W-1:0] dig_c;
  logic             blank_c;

  bin2bcd8 u_bin2bcd8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_c),
    .bin_i    (start_bin_c),
    .bcd_o    (bcd_c),
    .done_c_o (done_c)
  );

  // Control FSM and one-deep pending slot (last write wins).
  always_comb begin
    state_d     = state_q;
    cur_data_d  = cur_data_q;
    cur_mode_d  = cur_mode_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_mode_d = pend_mode_q;
    start_c     = 1'b0;
    start_bin_c = wr_data;
    load_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          cur_data_d  = wr_data;
          cur_mode_d  = mode;
          start_c     = mode;
          start_bin_c = wr_data;
          state_d     = mode ? CONV : LOAD;
        end
      end
      CONV: begin
        if (done_c) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_c = 1'b1;
        if (pend_vld_q) begin
          // Chain straight into the queued write without passing through IDLE.
          cur_data_d  = pend_data_q;
          cur_mode_d  = pend_mode_q;
          start_c     = pend_mode_q;
          start_bin_c = pend_data_q;
          pend_vld_d  = 1'b0;
          state_d     = pend_mode_q ? CONV : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en && (state_q != IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_data_d = wr_data;
      pend_mode_d = mode;
    end
  end

  // Atomic commit of digits, radix and digit count in LOAD.
  always_comb begin
    disp_d = disp_q;
    if (load_c) begin
      disp_d.dec    = cur_mode_q;
      disp_d.digits = cur_mode_q ? bcd_c : {4'h0, cur_data_q};
      disp_d.count  = cur_mode_q ? IDX_W'(MAX_DIGITS) : 2'd2;
    end
  end

  // Scan timing: digit index advances at each wrap and falls back to 0 when past the count.
  always_comb begin
    wrap_c = (scan_q == SCAN_LAST);
    scan_d = wrap_c ? '0 : scan_q + CNT_W'(1);
    idx_d  = idx_q;
    if (wrap_c) begin
      idx_d = ((idx_q + 2'd1) < disp_q.count) ? idx_q + 2'd1 : 2'd0;
    end
  end

  // Next anode and segment pattern, including decimal leading-zero blanking.
  always_comb begin
    dig_c   = '0;
    blank_c = 1'b0;
    unique case (idx_d)
      2'd0: dig_c = disp_d.digits[3:0];
      2'd1: begin
        dig_c   = disp_d.digits[7:4];
        blank_c = disp_d.dec && (disp_d.digits[11:8] == 4'd0) && (disp_d.digits[7:4] == 4'd0);
      end
      2'd2: begin
        dig_c   = disp_d.digits[11:8];
        blank_c = disp_d.dec && (disp_d.digits[11:8] == 4'd0);
      end
      default: blank_c = 1'b1;
    endcase
    seg_d  = blank_c ? SEG_BLANK : seg_lut(dig_c);
    an_d   = ~(8'b1 << idx_d);
    busy_d = (state_d != IDLE);
  end

  // State, display and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_data_q  <= '0;
      cur_mode_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_mode_q <= 1'b0;
      disp_q      <= DISP_RST;
      scan_q      <= '0;
      idx_q       <= '0;
      an_q        <= AN_RST;
      seg_q       <= SEG_ZERO;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_data_q  <= cur_data_d;
      cur_mode_q  <= cur_mode_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_mode_q <= pend_mode_d;
      disp_q      <= disp_d;
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      busy_q      <= busy_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = busy_q;
  assign dp   = 1'b1;

endmodule
